// File: rtl/game_input_pkg.sv
// ---------------------------------------------------------------------------
// game_input_pkg
// Shared types and constants for the BlackJack push-button front end.
//   cmd_t        : player command code handed to the game FSM
//   ctrl_state_t : handshake controller state
//   KEY_*        : bit index of each board key inside keys_n / keys_db
//   prio_cmd     : highest-priority command among simultaneous press events
// ---------------------------------------------------------------------------
package game_input_pkg;

   typedef enum logic [1:0] {
      CMD_HIT     = 2'd0,
      CMD_STAND   = 2'd1,
      CMD_DEAL    = 2'd2,
      CMD_NEWGAME = 2'd3
   } cmd_t;

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_PEND = 1'b1
   } ctrl_state_t;

   localparam int KEY_HIT     = 0;
   localparam int KEY_STAND   = 1;
   localparam int KEY_DEAL    = 2;
   localparam int KEY_NEWGAME = 3;
   localparam int NUM_KEYS    = 4;

   // NEWGAME beats DEAL beats STAND beats HIT; the losers are simply discarded.
   function automatic cmd_t prio_cmd(input logic [NUM_KEYS-1:0] ev);
      cmd_t c;
      if (ev[KEY_NEWGAME]) begin
         c = CMD_NEWGAME;
      end else if (ev[KEY_DEAL]) begin
         c = CMD_DEAL;
      end else if (ev[KEY_STAND]) begin
         c = CMD_STAND;
      end else begin
         c = CMD_HIT;
      end
      return c;
   endfunction

endpackage

// File: rtl/key_debouncer.sv
// ---------------------------------------------------------------------------
// key_debouncer
// One board key: 2-flop synchronizer, level debouncer and press pulse.
// Ports:
//   clk    in  system clock
//   reset  in  synchronous, active-high reset (restarts from "released")
//   key_n  in  raw key, active-low, asynchronous to clk
//   level  out debounced level, active-high (1 = pressed)
//   press  out one-cycle pulse in the cycle level rises 0->1
// Parameter DEBOUNCE_CYCLES (>=2): cycles a new level must be held.
// ---------------------------------------------------------------------------
module key_debouncer #(
   parameter int DEBOUNCE_CYCLES = 500000
) (
   input  logic clk,
   input  logic reset,
   input  logic key_n,
   output logic level,
   output logic press
);

   localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          sync1_r;
   logic          sync2_r;
   logic          level_r;
   logic          press_r;
   logic [CW-1:0] cnt_r;
   logic          pressed_s;

   assign pressed_s = ~sync2_r;

   // Synchronize the key, count how long it disagrees with the accepted level, flip on expiry.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_r <= 1'b1;
         sync2_r <= 1'b1;
         level_r <= 1'b0;
         press_r <= 1'b0;
         cnt_r   <= {CW{1'b0}};
      end else begin
         sync1_r <= key_n;
         sync2_r <= sync1_r;
         press_r <= 1'b0;
         if (pressed_s != level_r) begin
            if (cnt_r == CNT_LAST) begin
               level_r <= pressed_s;
               cnt_r   <= {CW{1'b0}};
               // only the rising edge is an event; releases are silent
               press_r <= pressed_s;
            end else begin
               cnt_r <= cnt_r + 1'b1;
            end
         end else begin
            cnt_r <= {CW{1'b0}};
         end
      end
   end

   assign level = level_r;
   assign press = press_r;

endmodule

// File: rtl/input_controller.sv
// ---------------------------------------------------------------------------
// input_controller
// Turns the four DE2 push-buttons into one-shot player commands for the
// BlackJack game FSM over a valid/ready handshake.
// Ports:
//   clk        in   system clock
//   reset      in   synchronous, active-high reset
//   keys_n     in   raw KEY[3:0], active-low; [0]=HIT [1]=STAND [2]=DEAL [3]=NEWGAME
//   cmd_valid  out  a command is pending
//   cmd        out  command code, stable while cmd_valid=1
//   cmd_ready  in   game FSM takes cmd when cmd_valid & cmd_ready
//   dropped    out  sticky: a press was lost while a command was pending;
//                   cleared by reset or an accepted CMD_NEWGAME
//   keys_db    out  debounced key levels, active-high
// Configuration macro: HIT_AUTOREPEAT_EN -- when defined, a held HIT key
// re-issues a HIT press every REPEAT_CYCLES cycles.
// ---------------------------------------------------------------------------
module input_controller
   import game_input_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int REPEAT_CYCLES   = 25000000
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [NUM_KEYS-1:0] keys_n,
   output logic                cmd_valid,
   output cmd_t                cmd,
   input  logic                cmd_ready,
   output logic                dropped,
   output logic [NUM_KEYS-1:0] keys_db
);

   logic [NUM_KEYS-1:0] press_s;
   logic [NUM_KEYS-1:0] level_s;
   logic [NUM_KEYS-1:0] ev_s;

   for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
      key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
         .clk   (clk),
         .reset (reset),
         .key_n (keys_n[i]),
         .level (level_s[i]),
         .press (press_s[i])
      );
   end

`ifdef HIT_AUTOREPEAT_EN
   localparam int RW = (REPEAT_CYCLES > 2) ? $clog2(REPEAT_CYCLES) : 1;
   localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CYCLES - 1);

   logic [RW-1:0] rep_cnt_r;
   logic          rep_r;

   // Free-running period counter while HIT is held; it sits at zero in the press cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         rep_cnt_r <= {RW{1'b0}};
         rep_r     <= 1'b0;
      end else if (!level_s[KEY_HIT]) begin
         rep_cnt_r <= {RW{1'b0}};
         rep_r     <= 1'b0;
      end else if (rep_cnt_r == REP_LAST) begin
         rep_cnt_r <= {RW{1'b0}};
         rep_r     <= 1'b1;
      end else begin
         rep_cnt_r <= rep_cnt_r + 1'b1;
         rep_r     <= 1'b0;
      end
   end

   // Masking with the live level stops a repeat landing in the cycle HIT is released.
   assign ev_s = {press_s[NUM_KEYS-1:1], press_s[KEY_HIT] | (rep_r & level_s[KEY_HIT])};
`else
   assign ev_s = press_s;
`endif

   ctrl_state_t state_r, state_nxt;
   cmd_t        cmd_r, cmd_nxt;
   logic        dropped_r, dropped_nxt;
   logic        any_ev_s;

   assign any_ev_s = |ev_s;

   // Handshake state, latched command and sticky drop flag.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r   <= S_IDLE;
         cmd_r     <= CMD_HIT;
         dropped_r <= 1'b0;
      end else begin
         state_r   <= state_nxt;
         cmd_r     <= cmd_nxt;
         dropped_r <= dropped_nxt;
      end
   end

   // Next-state logic: accept-cycle presses are latched back-to-back, others in PEND are dropped.
   always_comb begin
      state_nxt   = state_r;
      cmd_nxt     = cmd_r;
      dropped_nxt = dropped_r;
      case (state_r)
         S_IDLE: begin
            if (any_ev_s) begin
               state_nxt = S_PEND;
               cmd_nxt   = prio_cmd(ev_s);
            end else begin
               state_nxt = S_IDLE;
            end
         end
         S_PEND: begin
            if (cmd_ready) begin
               if (cmd_r == CMD_NEWGAME) begin
                  dropped_nxt = 1'b0;
               end else begin
                  dropped_nxt = dropped_r;
               end
               if (any_ev_s) begin
                  state_nxt = S_PEND;
                  cmd_nxt   = prio_cmd(ev_s);
               end else begin
                  state_nxt = S_IDLE;
               end
            end else begin
               if (any_ev_s) begin
                  dropped_nxt = 1'b1;
               end else begin
                  dropped_nxt = dropped_r;
               end
            end
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   assign cmd_valid = (state_r == S_PEND);
   assign cmd       = cmd_r;
   assign dropped   = dropped_r;
   assign keys_db   = level_s;

endmodule

// File: tb/tb_input_controller.sv
// ---------------------------------------------------------------------------
// tb_input_controller
// Directed scenarios with literal expectations, then randomized key/ready
// traffic. A behavioural model tracks the sampled key history (a key flips
// once it has been seen at the opposite level for DEBOUNCE_CYCLES samples
// in a row, two clocks after sampling) and a single-slot command mailbox;
// every negedge the DUT outputs are compared against it.
// ---------------------------------------------------------------------------
module tb_input_controller;
   import game_input_pkg::*;

   localparam int DEB  = 4;
   localparam int REP  = 16;
   localparam int HLEN = DEB + 2;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] keys_n;
   logic       cmd_valid;
   cmd_t       cmd;
   logic       cmd_ready;
   logic       dropped;
   logic [3:0] keys_db;

   always #5 clk = ~clk;

   input_controller #(.DEBOUNCE_CYCLES(DEB), .REPEAT_CYCLES(REP)) dut (
      .clk       (clk),
      .reset     (reset),
      .keys_n    (keys_n),
      .cmd_valid (cmd_valid),
      .cmd       (cmd),
      .cmd_ready (cmd_ready),
      .dropped   (dropped),
      .keys_db   (keys_db)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [3:0] hist [0:HLEN-1];   // hist[0] = sample taken at the latest edge
   logic [3:0] m_db;
   logic [3:0] m_ev;               // press events visible after the latest edge
   logic       m_pend;
   logic [1:0] m_cmd;
   logic       m_drop;
   int         since;

   function automatic logic [1:0] top_cmd(input logic [3:0] ev);
      for (int k = 3; k >= 0; k--) begin
         if (ev[k]) return 2'(k);
      end
      return 2'd0;
   endfunction

   task automatic model_step();
      logic [3:0] nev;
      logic       all_diff;
      if (reset) begin
         for (int k = 0; k < HLEN; k++) hist[k] = 4'd0;
         m_db = 4'd0; m_ev = 4'd0; m_pend = 1'b0; m_cmd = 2'd0; m_drop = 1'b0; since = 0;
         return;
      end
      // mailbox: events from the previous edge are consumed now
      if (m_pend && cmd_ready) begin
         if (m_cmd == 2'd3) m_drop = 1'b0;
         if (m_ev != 4'd0) m_cmd = top_cmd(m_ev);
         else m_pend = 1'b0;
      end else if (m_pend) begin
         if (m_ev != 4'd0) m_drop = 1'b1;
      end else if (m_ev != 4'd0) begin
         m_pend = 1'b1;
         m_cmd  = top_cmd(m_ev);
      end
      // key history and debounced levels
      for (int k = HLEN - 1; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = ~keys_n;
      nev = 4'd0;
      for (int i = 0; i < 4; i++) begin
         all_diff = 1'b1;
         for (int j = 2; j < HLEN; j++) begin
            if (hist[j][i] == m_db[i]) all_diff = 1'b0;
         end
         if (all_diff) begin
            m_db[i] = ~m_db[i];
            nev[i]  = m_db[i];
         end
      end
`ifdef HIT_AUTOREPEAT_EN
      if (m_db[0]) begin
         if (nev[0]) since = 0;
         else begin
            since++;
            if (since % REP == 0) nev[0] = 1'b1;
         end
      end else begin
         since = 0;
      end
`endif
      m_ev = nev;
   endtask

   initial begin
      forever begin
         @(posedge clk);
         model_step();
      end
   end

   // ---------------- compare process ----------------
   logic chk_en = 1'b0;
   int   valid_cycles = 0;
   int   accepts = 0;
   int   kdb1_cycles = 0;
   cmd_t last_cmd = CMD_HIT;

   initial begin
      forever begin
         @(negedge clk);
         if (chk_en) begin
            check("cmd_valid", {3'd0, cmd_valid}, {3'd0, m_pend});
            check("cmd", {2'd0, cmd}, {2'd0, m_cmd});
            check("dropped", {3'd0, dropped}, {3'd0, m_drop});
            check("keys_db", keys_db, m_db);
            if (cmd_valid) begin
               valid_cycles++;
               last_cmd = cmd;
               if (cmd_ready) accepts++;
            end
            if (keys_db[1]) kdb1_cycles++;
         end
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int v0;
      int k0;
      reset = 1'b1; keys_n = 4'hF; cmd_ready = 1'b0;
      // 1: reset held 3 clocks
      cyc(3);
      chk_en = 1'b1;
      check("rst_valid", {3'd0, cmd_valid}, 4'd0);
      check("rst_dropped", {3'd0, dropped}, 4'd0);
      check("rst_keys_db", keys_db, 4'd0);
      check("rst_cmd", {2'd0, cmd}, 4'd0);
      reset = 1'b0;

      // 2: HIT held 10 clocks -> exactly one HIT
      cmd_ready = 1'b1;
      v0 = valid_cycles;
      keys_n = 4'b1110; cyc(10); keys_n = 4'hF; cyc(15);
      check("hit_count", 4'(valid_cycles - v0), 4'd1);
      check("hit_cmd", {2'd0, last_cmd}, 4'd0);

      // 3: STAND glitch of 3 clocks is ignored
      v0 = valid_cycles; k0 = kdb1_cycles;
      keys_n = 4'b1101; cyc(3); keys_n = 4'hF; cyc(10);
      check("glitch_count", 4'(valid_cycles - v0), 4'd0);
      check("glitch_db", 4'(kdb1_cycles - k0), 4'd0);

      // 4: DEAL + NEWGAME together -> one NEWGAME, no drop
      v0 = valid_cycles;
      keys_n = 4'b0011; cyc(10); keys_n = 4'hF; cyc(15);
      check("prio_count", 4'(valid_cycles - v0), 4'd1);
      check("prio_cmd", {2'd0, last_cmd}, 4'd3);
      check("prio_dropped", {3'd0, dropped}, 4'd0);

      // 5: STAND pending, HIT arrives -> dropped, STAND held; then accept
      cmd_ready = 1'b0;
      keys_n = 4'b1101; cyc(10); keys_n = 4'hF; cyc(10);
      keys_n = 4'b1110; cyc(10); keys_n = 4'hF; cyc(10);
      check("pend_valid", {3'd0, cmd_valid}, 4'd1);
      check("pend_cmd", {2'd0, cmd}, 4'd1);
      check("pend_dropped", {3'd0, dropped}, 4'd1);
      cmd_ready = 1'b1; cyc(1);
      check("accept_valid", {3'd0, cmd_valid}, 4'd0);
      check("sticky_dropped", {3'd0, dropped}, 4'd1);

      // 6: pending DEAL killed by reset
      cmd_ready = 1'b0;
      keys_n = 4'b1011; cyc(10); keys_n = 4'hF; cyc(10);
      check("deal_valid", {3'd0, cmd_valid}, 4'd1);
      check("deal_cmd", {2'd0, cmd}, 4'd2);
      reset = 1'b1; cyc(1);
      check("rst_mid_valid", {3'd0, cmd_valid}, 4'd0);
      check("rst_mid_dropped", {3'd0, dropped}, 4'd0);
      cyc(2); reset = 1'b0; cyc(2);

`ifdef HIT_AUTOREPEAT_EN
      // HIT held 40 clocks -> three HITs with REPEAT_CYCLES=16
      cmd_ready = 1'b1;
      v0 = accepts;
      keys_n = 4'b1110; cyc(40); keys_n = 4'hF; cyc(20);
      check("repeat_count", 4'(accepts - v0), 4'd3);
`endif

      // randomized traffic against the model
      for (int c = 0; c < 3000; c++) begin
         for (int i = 0; i < 4; i++) begin
            if ($urandom_range(5, 0) == 0) keys_n[i] = ~keys_n[i];
         end
         cmd_ready = ($urandom_range(1, 0) == 1);
         reset = ($urandom_range(399, 0) == 0);
         cyc(1);
      end
      reset = 1'b0; keys_n = 4'hF; cmd_ready = 1'b1;
      cyc(20);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
